ni_tx_ctrl: RTL and testbench
=============================

Name: ni_tx_ctrl

Overview:
- Injection-side controller for the network interface.
- Pops 64-bit {data[63:32], addr[31:0]} entries from the NI write FIFO and turns each entry into a 3-flit packet (head, body, tail).
- Drives packets into the local router input port under credit-based flow control.
- Sits between the gp_fifo read port and the router; sequences FIFO reads, flit formation and credit accounting.

Parameters:
- CREDITS, 4: router input buffer depth, in flits. Initial and maximum credit count.
- MY_ID, 4'h0: source node id placed in head flits.
- CNT_W, 16: width of the packet counter.

Ports:
- aclk  in  1  clock.
- arestn  in  1  asynchronous active-low reset.
- enable  in  1  allows new packets to start.
- fifo_data  in  64  FIFO data_out, {data, addr}.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  one-cycle FIFO pop.
- flit_valid  out  1  flit transferred this cycle.
- flit_data  out  34  [33:32] type (01 head, 00 body, 10 tail), [31:0] payload.
- credit_in  in  1  one credit returned by the router this cycle.
- busy  out  1  state != IDLE.
- pkt_count  out  CNT_W  packets completed, wraps.
- credit_err  out  1  sticky: credit returned while the counter is already at CREDITS.

Behaviour:
- Reset (arestn low, asynchronous):
  - State = IDLE; credit_cnt = CREDITS; captured entry = 0.
  - pkt_count = 0, credit_err = 0, fifo_read_en = 0, flit_valid = 0, flit_data = 0, busy = 0.
- FIFO contract: fifo_data is valid the cycle after fifo_read_en. fifo_read_en is never asserted while fifo_empty = 1.
- State machine, one transition per aclk edge:
  - IDLE: if enable && !fifo_empty, assert fifo_read_en (combinational, this cycle only) and go to FETCH. Otherwise stay.
  - FETCH: capture fifo_data into entry_q; go to HEAD.
  - HEAD: if credit_cnt != 0, flit_valid = 1 with flit_data = {2'b01, entry_q[31:28] (dest), MY_ID, 24'h0}; go to BODY. Else hold with flit_valid = 0.
  - BODY: same credit rule; flit_data = {2'b00, entry_q[31:0]}; go to TAIL.
  - TAIL: same credit rule; flit_data = {2'b10, entry_q[63:32]}; pkt_count += 1 (wraps at 2^CNT_W); go to IDLE.
- flit_valid and flit_data are combinational from state, entry_q and credit_cnt. flit_data = 0 whenever flit_valid = 0.
- Latency: read_en to head flit is 2 cycles with credits available. Minimum packet period is 5 cycles.
- Credit counter:
  - sent = flit_valid.
  - sent && !credit_in: decrement.
  - !sent && credit_in: increment, unless credit_cnt == CREDITS, in which case it saturates and sets credit_err.
  - Both: unchanged, no error.
  - The counter never goes below 0.
- enable deasserted mid-packet: the current packet completes; no new pop occurs.
- A stall on zero credits can occur at any flit. The flit is held, not skipped or duplicated.
- Reset mid-packet: the packet is aborted and the popped entry is lost (accepted behaviour). The router side is reset by the same arestn.
- credit_err clears only on reset.

Test Plan:
- MY_ID=3, one entry {32'hDEADBEEF, 32'h5000_0010}, CREDITS=4 -> fifo_read_en pulse, then over 3 consecutive cycles starting 2 cycles later: 34'h1_5300_0000, 34'h0_5000_0010, 34'h2_DEADBEEF. After the tail: pkt_count=1, credit_cnt=1.
- Two queued entries, no credit_in, CREDITS=4 -> 4 flits sent, then the stall holds the second packet's body in BODY with flit_valid=0. A single credit_in pulse releases exactly one flit (the body), then the stall resumes at TAIL.
- credit_in asserted in the same cycle as a sent flit with credit_cnt=1 -> credit_cnt stays 1, no error, next flit proceeds.
- credit_in with credit_cnt=4 (idle after reset) -> credit_cnt stays 4, credit_err=1 and remains set.
- enable dropped during BODY -> the tail is still sent, no further fifo_read_en while fifo_empty=0.
- arestn low during BODY -> all outputs 0 immediately (asynchronous), credit_cnt=4, pkt_count=0. After release, the next queued entry yields a fresh head flit.

Source files
------------

// File: rtl/ni_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ni_tx_ctrl_if
// Description : Groups the NI injection-side signals into one bundle.
//               FIFO read port: fifo_data, fifo_empty, fifo_read_en.
//               Router input port: flit_valid, flit_data, credit_in.
//               master = the injection controller, slave = FIFO + router.
// Revision    : 1.0  initial release
// ============================================================================
interface ni_tx_ctrl_if;
  logic [63:0] fifo_data;     // {data[63:32], addr[31:0]}, valid the cycle after a pop
  logic        fifo_empty;
  logic        fifo_read_en;  // one-cycle pop strobe
  logic        flit_valid;    // flit transferred this cycle
  logic [33:0] flit_data;     // [33:32] type, [31:0] payload
  logic        credit_in;     // one credit returned by the router

  modport master (
    input  fifo_data,
    input  fifo_empty,
    input  credit_in,
    output fifo_read_en,
    output flit_valid,
    output flit_data
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    output credit_in,
    input  fifo_read_en,
    input  flit_valid,
    input  flit_data
  );
endinterface
`default_nettype wire

// File: rtl/ni_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ni_tx_ctrl
// Description : NI injection controller. Pops {data, addr} entries from the
//               write FIFO and sends each as a head/body/tail packet into
//               the local router under credit-based flow control.
// Ports       : aclk, arestn      clock, asynchronous active-low reset
//               enable            allows new packets to start
//               nif (master)      FIFO read port + router flit/credit port
//               busy              controller is not idle
//               pkt_count         completed packets, wraps
//               credit_err        sticky: credit returned with counter full
// Revision    : 1.0  initial release
// ============================================================================
module ni_tx_ctrl #(
  parameter int         CREDITS = 4,
  parameter logic [3:0] MY_ID   = 4'h0,
  parameter int         CNT_W   = 16
) (
  input  wire logic       aclk,
  input  wire logic       arestn,
  input  wire logic       enable,
  ni_tx_ctrl_if.master    nif,
  output logic            busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic            credit_err
);

  localparam int                  c_CRED_W   = $clog2(CREDITS + 1);
  localparam logic [c_CRED_W-1:0] c_CRED_MAX = c_CRED_W'(CREDITS);
  localparam logic [c_CRED_W-1:0] c_CRED_ONE = c_CRED_W'(1);
  localparam logic [CNT_W-1:0]    c_PKT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_HEAD  = 3'd2,
    S_BODY  = 3'd3,
    S_TAIL  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [63:0]           r_entry;
  logic [c_CRED_W-1:0]   r_credit_cnt;
  logic [CNT_W-1:0]      r_pkt_count;
  logic                  r_credit_err;
  logic                  w_has_credit;
  logic                  w_read_en;
  logic                  w_flit_valid;
  logic [33:0]           w_flit_data;

  assign w_has_credit = (r_credit_cnt != '0);

  // Next state and flit outputs. A flit stage without credit simply holds,
  // so the same flit is re-presented once a credit arrives.
  always_comb begin
    w_state_nxt  = r_state;
    w_read_en    = 1'b0;
    w_flit_valid = 1'b0;
    w_flit_data  = '0;
    case (r_state)
      S_IDLE: begin
        // Gated by arestn so the pop strobe is low while reset is held.
        if (enable && !nif.fifo_empty && arestn) begin
          w_read_en   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_HEAD;
      end
      S_HEAD: begin
        if (w_has_credit) begin
          w_flit_valid = 1'b1;
          w_flit_data  = {2'b01, r_entry[31:28], MY_ID, 24'h0};
          w_state_nxt  = S_BODY;
        end
      end
      S_BODY: begin
        if (w_has_credit) begin
          w_flit_valid = 1'b1;
          w_flit_data  = {2'b00, r_entry[31:0]};
          w_state_nxt  = S_TAIL;
        end
      end
      S_TAIL: begin
        if (w_has_credit) begin
          w_flit_valid = 1'b1;
          w_flit_data  = {2'b10, r_entry[63:32]};
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      r_entry     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (r_state == S_FETCH) begin
        r_entry <= nif.fifo_data;
      end
      if ((r_state == S_TAIL) && w_flit_valid) begin
        r_pkt_count <= r_pkt_count + c_PKT_ONE;
      end
    end
  end

  // Credit counter. A send and a returned credit in the same cycle cancel.
  // A send is only possible with a non-zero count, so it cannot underflow.
  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      r_credit_cnt <= c_CRED_MAX;
      r_credit_err <= 1'b0;
    end else begin
      case ({w_flit_valid, nif.credit_in})
        2'b10: r_credit_cnt <= r_credit_cnt - c_CRED_ONE;
        2'b01: begin
          if (r_credit_cnt == c_CRED_MAX) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credit_cnt <= r_credit_cnt + c_CRED_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign nif.fifo_read_en = w_read_en;
  assign nif.flit_valid   = w_flit_valid;
  assign nif.flit_data    = w_flit_data;
  assign busy             = (r_state != S_IDLE);
  assign pkt_count        = r_pkt_count;
  assign credit_err       = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_ni_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ni_tx_ctrl
// Description : Self-checking bench for ni_tx_ctrl. A FIFO/router model
//               drives the interface; a monitor compares every cycle against
//               a packet-level reference (expected flit queue, router buffer
//               occupancy, packet phase since pop).
// Revision    : 1.0  initial release
// ============================================================================
module tb_ni_tx_ctrl;
  localparam int         CREDITS = 4;
  localparam logic [3:0] MY_ID   = 4'h3;
  localparam int         CNT_W   = 4;

  logic             aclk   = 1'b0;
  logic             arestn = 1'b0;
  logic             enable = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] pkt_count;
  logic             credit_err;

  ni_tx_ctrl_if nif ();

  ni_tx_ctrl #(.CREDITS(CREDITS), .MY_ID(MY_ID), .CNT_W(CNT_W)) dut (
    .aclk      (aclk),
    .arestn    (arestn),
    .enable    (enable),
    .nif       (nif.master),
    .busy      (busy),
    .pkt_count (pkt_count),
    .credit_err(credit_err)
  );

  always #5 aclk = ~aclk;

  // stimulus storage (main writes, others read)
  logic [63:0] ent [0:255];
  int          wr_idx      = 0;
  int          man_req     = 0;
  bit          credit_mode = 1'b0;  // 1: router returns credits randomly
  int          timeout_req = 0;
  bit          end_req     = 1'b0;
  // service-process state
  int          pops_done   = 0;
  int          man_used    = 0;
  // monitor / reference model state
  int          pops_seen    = 0;
  int          timeout_seen = 0;
  bit          end_done     = 1'b0;
  int          checks       = 0;
  int          failures     = 0;
  int          occ          = 0;   // flits sitting in the router buffer
  int          exp_pkt      = 0;
  int          phase        = 0;   // cycles since the pop of the current packet
  bit          exp_busy     = 1'b0;
  bit          exp_err      = 1'b0;
  logic [33:0] sb [$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // FIFO and router model: serves pops and returns credits.
  initial begin
    nif.fifo_data  = '0;
    nif.fifo_empty = 1'b1;
    nif.credit_in  = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (pops_done < pops_seen) begin
        nif.fifo_data = ent[pops_done];
        pops_done++;
      end
      nif.fifo_empty = (pops_done >= wr_idx);
      if (!arestn) begin
        nif.credit_in = 1'b0;
      end else if (credit_mode) begin
        nif.credit_in = (occ > 0) && ($urandom_range(0, 1) == 1);
      end else if (man_used < man_req) begin
        nif.credit_in = 1'b1;
        man_used++;
      end else begin
        nif.credit_in = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge aclk or negedge arestn) begin
    if (!arestn) begin
      #1;
      chk("rst_read_en",    64'(nif.fifo_read_en), 64'(0));
      chk("rst_flit_valid", 64'(nif.flit_valid),   64'(0));
      chk("rst_flit_data",  64'(nif.flit_data),    64'(0));
      chk("rst_busy",       64'(busy),             64'(0));
      chk("rst_pkt_count",  64'(pkt_count),        64'(0));
      chk("rst_credit_err", 64'(credit_err),       64'(0));
      chk("rst_credit_cnt", 64'(dut.r_credit_cnt), 64'(CREDITS));
      occ = 0; exp_pkt = 0; phase = 0; exp_busy = 1'b0; exp_err = 1'b0;
      sb.delete();
    end else begin
      logic        rv, fv, ci, exp_rd, exp_fv, tail;
      logic [33:0] fd, ef;
      logic [63:0] e;
      rv = nif.fifo_read_en; fv = nif.flit_valid; fd = nif.flit_data; ci = nif.credit_in;
      tail = 1'b0;

      exp_rd = !exp_busy && enable && !nif.fifo_empty;
      chk("read_en", 64'(rv), 64'(exp_rd));
      if (exp_busy) phase++;
      exp_fv = exp_busy && (phase >= 2) && (occ < CREDITS);
      chk("flit_valid", 64'(fv), 64'(exp_fv));
      if (fv) begin
        if (sb.size() == 0) begin
          chk("unexpected_flit", 64'(fd), 64'(0));
        end else begin
          ef = sb.pop_front();
          chk("flit_data", 64'(fd), 64'(ef));
          tail = (ef[33:32] == 2'b10);
        end
      end else begin
        chk("idle_flit_data", 64'(fd), 64'(0));
      end
      chk("credit_cnt", 64'(dut.r_credit_cnt), 64'(CREDITS - occ));
      chk("pkt_count",  64'(pkt_count),        64'(exp_pkt));
      chk("credit_err", 64'(credit_err),       64'(exp_err));
      chk("busy",       64'(busy),             64'(exp_busy));

      // advance the reference across the coming edge
      if (ci && !fv && occ == 0) exp_err = 1'b1;
      if (fv && !ci) occ++;
      else if (!fv && ci && occ > 0) occ--;
      if (tail) begin
        exp_pkt  = (exp_pkt + 1) % (1 << CNT_W);
        exp_busy = 1'b0;
      end
      if (rv) begin
        e = ent[pops_seen];
        pops_seen++;
        sb.push_back({2'b01, e[31:28], MY_ID, 24'h0});
        sb.push_back({2'b00, e[31:0]});
        sb.push_back({2'b10, e[63:32]});
        exp_busy = 1'b1;
        phase    = 0;
      end

      if (timeout_seen != timeout_req) begin
        checks++;
        failures++;
        timeout_seen++;
        $display("FAIL timeout actual=expired required=event at %0t", $time);
      end
      if (end_req && !end_done) begin
        chk("end_scoreboard_empty", 64'(sb.size()), 64'(0));
        chk("end_fifo_drained",     64'(pops_seen), 64'(wr_idx));
        end_done = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic push(input logic [63:0] e);
    ent[wr_idx] = e;
    wr_idx++;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    step(2);
    while (!(pops_seen == wr_idx && !busy) && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) timeout_req++;
  endtask

  task automatic wait_head(input int budget);
    int k;
    k = 0;
    while (!(nif.flit_valid && nif.flit_data[33:32] == 2'b01) && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) timeout_req++;
  endtask

  task automatic wait_drained(input int budget);
    int k;
    k = 0;
    while (occ != 0 && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) timeout_req++;
  endtask

  initial begin
    step(2);
    arestn = 1'b1;
    step(1);

    // single packet, no credits returned
    push({32'hDEADBEEF, 32'h5000_0010});
    enable = 1'b1;
    wait_idle(30);
    man_req += 3;
    step(5);

    // credit stall on the second packet's body, then single-credit release
    push({32'h1111_2222, 32'hA000_0001});
    push({32'h3333_4444, 32'hB000_0002});
    step(16);
    man_req += 1;
    step(5);
    // credit arrives in the same cycle the tail goes out with one credit left
    man_req += 2;
    step(5);
    man_req += 3;
    step(5);

    // enable dropped while a packet is in flight
    credit_mode = 1'b1;
    push({32'h5555_6666, 32'hC000_0003});
    push({32'h7777_8888, 32'hD000_0004});
    wait_head(30);
    step(1);
    enable = 1'b0;
    step(20);
    enable = 1'b1;
    wait_idle(60);

    // spurious credit while the counter is full
    wait_drained(100);
    credit_mode = 1'b0;
    man_req += 1;
    step(6);

    // reset while the body flit is pending
    credit_mode = 1'b1;
    push({32'h9999_AAAA, 32'hE000_0005});
    push({32'hBBBB_CCCC, 32'hF000_0006});
    wait_head(30);
    @(posedge aclk);
    #3;
    arestn = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    #2;
    arestn = 1'b1;
    wait_idle(60);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0 && wr_idx < 250) push({$urandom, $urandom});
      enable = ($urandom_range(0, 9) != 0);
      step(1);
    end
    enable = 1'b1;
    wait_idle(3000);
    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_done; k++) step(1);
    if (!end_done) begin
      $display("FAIL end_check actual=not_reached required=reached");
      $fatal(1, "end check not reached");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
